// File: rtl/bp_ethernet_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the Ethernet MAC transmit path.
// Holds the link for a whole frame, truncates oversize frames, and inserts an IFG.
module bp_ethernet_tx_arbiter #(
    parameter int els_p             = 2,
    parameter int data_width_p      = 8,
    parameter int max_frame_words_p = 1518,
    parameter int ifg_cycles_p      = 12,
    localparam int id_width_lp      = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [els_p*data_width_p-1:0]   req_data_i,
    input  logic [els_p-1:0]                req_last_i,
    input  logic [els_p-1:0]                req_v_i,
    output logic [els_p-1:0]                req_ready_and_o,
    output logic [data_width_p-1:0]         tx_data_o,
    output logic                            tx_last_o,
    output logic                            tx_v_o,
    input  logic                            tx_ready_and_i,
    output logic [id_width_lp-1:0]          tx_src_id_o,
    output logic [els_p-1:0]                oversize_err_o,
    input  logic [els_p-1:0]                err_clear_i,
    output logic                            busy_o
);

    localparam int wcnt_width_lp = $clog2(max_frame_words_p + 1);
    localparam int gcnt_width_lp =
        (ifg_cycles_p > 0) ? $clog2(ifg_cycles_p + 1) : 1;

    typedef enum logic [1:0] {
        e_idle,
        e_send,
        e_drain,
        e_gap
    } state_e;

    state_e                   state_r, state_n;
    logic [id_width_lp-1:0]   grant_r, grant_n;
    logic [id_width_lp-1:0]   rr_ptr_r, rr_ptr_n;
    logic [wcnt_width_lp-1:0] word_cnt_r, word_cnt_n;
    logic [gcnt_width_lp-1:0] gap_cnt_r, gap_cnt_n;
    logic [els_p-1:0]         err_r, err_n;
    logic [els_p-1:0]         set_err;

    logic                     pick_v;
    logic [id_width_lp-1:0]   pick_id;
    logic [id_width_lp-1:0]   pick_next;

    logic [data_width_p-1:0]  sel_data;
    logic                     sel_v;
    logic                     sel_last;
    logic                     at_max;
    logic                     gap_done;
    state_e                   frame_end_state;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_idle;
            grant_r    <= '0;
            rr_ptr_r   <= '0;
            word_cnt_r <= '0;
            gap_cnt_r  <= '0;
            err_r      <= '0;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            rr_ptr_r   <= rr_ptr_n;
            word_cnt_r <= word_cnt_n;
            gap_cnt_r  <= gap_cnt_n;
            err_r      <= err_n;
        end
    end

    // Scan upward from rr_ptr, wrapping modulo els_p
    always_comb begin : scan
        int idx;
        pick_v  = 1'b0;
        pick_id = '0;
        idx     = 0;
        for (int k = 0; k < els_p; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= els_p) idx = idx - els_p;
            if (!pick_v && req_v_i[idx]) begin
                pick_v  = 1'b1;
                pick_id = id_width_lp'(idx);
            end
        end
    end

    assign pick_next = (int'(pick_id) == els_p - 1)
                     ? '0
                     : pick_id + id_width_lp'(1);

    assign sel_data = req_data_i[grant_r*data_width_p +: data_width_p];
    assign sel_v    = req_v_i[grant_r];
    assign sel_last = req_last_i[grant_r];

    assign at_max   = (word_cnt_r ==
                       wcnt_width_lp'(max_frame_words_p - 1));
    assign gap_done = (gap_cnt_r ==
                       gcnt_width_lp'(ifg_cycles_p - 1));

    assign frame_end_state = (ifg_cycles_p > 0) ? e_gap : e_idle;

    always_comb begin
        state_n         = state_r;
        grant_n         = grant_r;
        rr_ptr_n        = rr_ptr_r;
        word_cnt_n      = word_cnt_r;
        gap_cnt_n       = gap_cnt_r;
        set_err         = '0;
        tx_v_o          = 1'b0;
        tx_last_o       = 1'b0;
        tx_data_o       = '0;
        req_ready_and_o = '0;

        unique case (state_r)
            e_idle: begin
                if (pick_v) begin
                    grant_n    = pick_id;
                    rr_ptr_n   = pick_next;
                    word_cnt_n = '0;
                    state_n    = e_send;
                end
            end
            e_send: begin
                tx_v_o    = sel_v;
                tx_data_o = sel_data;
                tx_last_o = sel_v & (sel_last | at_max);
                req_ready_and_o[grant_r] = tx_ready_and_i;
                if (sel_v && tx_ready_and_i) begin
                    word_cnt_n = word_cnt_r + wcnt_width_lp'(1);
                    if (sel_last) begin
                        gap_cnt_n = '0;
                        state_n   = frame_end_state;
                    end else if (at_max) begin
                        set_err[grant_r] = 1'b1;
                        state_n          = e_drain;
                    end
                end
            end
            // Swallow the rest of a truncated frame up to its real last word
            e_drain: begin
                req_ready_and_o[grant_r] = 1'b1;
                if (sel_v && sel_last) begin
                    gap_cnt_n = '0;
                    state_n   = frame_end_state;
                end
            end
            e_gap: begin
                if (gap_done) begin
                    state_n = e_idle;
                end else begin
                    gap_cnt_n = gap_cnt_r + gcnt_width_lp'(1);
                end
            end
            default: state_n = e_idle;
        endcase
    end

    assign err_n = (err_r & ~err_clear_i) | set_err;

    assign oversize_err_o = err_r;
    assign busy_o         = (state_r != e_idle);
    assign tx_src_id_o    = (state_r == e_send || state_r == e_drain)
                          ? grant_r : '0;

endmodule
